// File: rtl/audio_attr_bank_pkg.sv
// ---------------------------------------------------------------------------
// audio_attr_bank_pkg
// Shared audio definitions for the channel attribute store:
//   - default channel count and bytes per channel word
//   - index-width and byte-lane helpers used to size address fields
//   - encodings of the clear sequencer states
// ---------------------------------------------------------------------------
package audio_attr_bank_pkg;

    localparam int AUDIO_NUM_CH     = 16;
    localparam int AUDIO_ATTR_BYTES = 4;

    // Clear sequencer states: IDLE accepts host writes, CLEAR owns the
    // single write port while it zeroes the array.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

    // Bits needed to index n entries; never less than one so that a field
    // declared from it is always legal.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Bit position of the least significant bit of a byte lane.
    function automatic int lane_lsb(input int lane);
        return 8 * lane;
    endfunction

endpackage

// File: rtl/audio_attr_clear_seq.sv
// ---------------------------------------------------------------------------
// audio_attr_clear_seq
// Walks every channel index once, asserting a clear write per cycle, after
// reset and whenever clear_i is pulsed. A new clear_i restarts the walk.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   clear_i      start (or restart) a full clear
//   busy_o       clear walk in progress
//   clr_we_o     zero the entry at clr_addr_o this cycle
//   clr_addr_o   entry being cleared
// ---------------------------------------------------------------------------
module audio_attr_clear_seq
    import audio_attr_bank_pkg::*;
#(
    parameter  int NUM_CH = AUDIO_NUM_CH,
    localparam int CH_W   = idx_w(NUM_CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear_i,
    output logic            busy_o,
    output logic            clr_we_o,
    output logic [CH_W-1:0] clr_addr_o
);

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    clr_state_t      state_q, state_d;
    logic [CH_W-1:0] cnt_q, cnt_d;

    // Reset lands in CLEAR so the array is scrubbed before first use.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The entry at cnt_q is cleared on every CLEAR edge; the edge that
    // clears the last entry returns to IDLE.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        busy_o     = 1'b0;
        clr_we_o   = 1'b0;
        clr_addr_o = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_i) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                busy_o   = 1'b1;
                clr_we_o = 1'b1;
                if (clear_i) begin
                    cnt_d = '0;
                end else if (cnt_q == LAST_CH) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/audio_attr_bank.sv
// ---------------------------------------------------------------------------
// audio_attr_bank
// Per-channel attribute store: host writes single bytes, the audio engine
// reads a whole channel word with one cycle of latency. A clear sequencer
// zeroes the array after reset and on demand; host writes during a clear
// are dropped and flagged.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   wr_en_i      host byte write strobe
//   wr_addr_i    {channel, byte lane}, lane in the low bits
//   wr_data_i    byte to write
//   rd_en_i      engine read request
//   rd_addr_i    channel to read
//   rd_data_o    channel word, byte 0 in bits [7:0]
//   rd_valid_o   rd_data_o was updated by the previous request
//   clear_i      start a full clear
//   busy_o       clear in progress
//   wr_drop_o    a host write was discarded because of a clear
// ---------------------------------------------------------------------------
module audio_attr_bank
    import audio_attr_bank_pkg::*;
#(
    parameter  int NUM_CH       = AUDIO_NUM_CH,
    parameter  int BYTES_PER_CH = AUDIO_ATTR_BYTES,
    parameter  bit WRITE_FIRST  = 1'b1,
    localparam int CH_W         = idx_w(NUM_CH),
    localparam int BS_W         = idx_w(BYTES_PER_CH),
    localparam int DW           = 8 * BYTES_PER_CH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en_i,
    input  logic [CH_W+BS_W-1:0] wr_addr_i,
    input  logic [7:0]           wr_data_i,
    input  logic                 rd_en_i,
    input  logic [CH_W-1:0]      rd_addr_i,
    output logic [DW-1:0]        rd_data_o,
    output logic                 rd_valid_o,
    input  logic                 clear_i,
    output logic                 busy_o,
    output logic                 wr_drop_o
);

    logic [DW-1:0]   mem [NUM_CH];

    logic            clr_we;
    logic [CH_W-1:0] clr_addr;
    logic [CH_W-1:0] wr_ch;
    logic [BS_W-1:0] wr_lane;
    logic            wr_accept;
    logic            collide;
    logic [DW-1:0]   old_word;
    logic [DW-1:0]   fwd_word;
    logic [DW-1:0]   rd_next;

    audio_attr_clear_seq #(
        .NUM_CH (NUM_CH)
    ) u_clear_seq (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (clear_i),
        .busy_o     (busy_o),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr)
    );

    assign wr_ch     = wr_addr_i[BS_W +: CH_W];
    assign wr_lane   = wr_addr_i[BS_W-1:0];
    assign wr_accept = wr_en_i & ~busy_o;
    assign collide   = rd_en_i & wr_accept & (wr_ch == rd_addr_i);
    assign old_word  = mem[rd_addr_i];

    // The clear sequencer owns the single write port while busy; host
    // writes only reach the array when the sequencer is idle.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_accept) begin
            for (int b = 0; b < BYTES_PER_CH; b++) begin
                if (wr_lane == BS_W'(b)) begin
                    mem[wr_ch][lane_lsb(b) +: 8] <= wr_data_i;
                end
            end
        end
    end

    // Forwarded word for a same-channel collision: stored word with the
    // lane being written replaced by the incoming byte.
    always_comb begin
        fwd_word = old_word;
        for (int b = 0; b < BYTES_PER_CH; b++) begin
            if (wr_lane == BS_W'(b)) begin
                fwd_word[lane_lsb(b) +: 8] = wr_data_i;
            end
        end
    end

    // While clearing, entries not yet reached still hold stale data, so
    // reads are forced to zero rather than exposing them.
    always_comb begin
        rd_next = old_word;
        if (busy_o) begin
            rd_next = '0;
        end else if (WRITE_FIRST && collide) begin
            rd_next = fwd_word;
        end
    end

    // Read register holds its value between requests; the drop flag
    // reports a write that arrived while the sequencer was busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_o  <= '0;
            rd_valid_o <= 1'b0;
            wr_drop_o  <= 1'b0;
        end else begin
            rd_valid_o <= rd_en_i;
            wr_drop_o  <= wr_en_i & busy_o;
            if (rd_en_i) begin
                rd_data_o <= rd_next;
            end
        end
    end

endmodule

// File: tb/tb_audio_attr_bank.sv
// ---------------------------------------------------------------------------
// tb_audio_attr_bank
// Directed bench for audio_attr_bank. Instance A uses the default geometry
// with write-first forwarding; instance B is 4 channels x 2 bytes with
// read-first behaviour.
// ---------------------------------------------------------------------------
module tb_audio_attr_bank;

    logic        clk;
    logic        rst;

    logic        a_wr_en;
    logic [5:0]  a_wr_addr;
    logic [7:0]  a_wr_data;
    logic        a_rd_en;
    logic [3:0]  a_rd_addr;
    logic [31:0] a_rd_data;
    logic        a_rd_valid;
    logic        a_clear;
    logic        a_busy;
    logic        a_wr_drop;

    logic        b_wr_en;
    logic [2:0]  b_wr_addr;
    logic [7:0]  b_wr_data;
    logic        b_rd_en;
    logic [1:0]  b_rd_addr;
    logic [15:0] b_rd_data;
    logic        b_rd_valid;
    logic        b_clear;
    logic        b_busy;
    logic        b_wr_drop;

    int          errors;
    int          checks;

    audio_attr_bank #(
        .NUM_CH       (16),
        .BYTES_PER_CH (4),
        .WRITE_FIRST  (1'b1)
    ) dut_a (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (a_wr_en),
        .wr_addr_i  (a_wr_addr),
        .wr_data_i  (a_wr_data),
        .rd_en_i    (a_rd_en),
        .rd_addr_i  (a_rd_addr),
        .rd_data_o  (a_rd_data),
        .rd_valid_o (a_rd_valid),
        .clear_i    (a_clear),
        .busy_o     (a_busy),
        .wr_drop_o  (a_wr_drop)
    );

    audio_attr_bank #(
        .NUM_CH       (4),
        .BYTES_PER_CH (2),
        .WRITE_FIRST  (1'b0)
    ) dut_b (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (b_wr_en),
        .wr_addr_i  (b_wr_addr),
        .wr_data_i  (b_wr_data),
        .rd_en_i    (b_rd_en),
        .rd_addr_i  (b_rd_addr),
        .rd_data_o  (b_rd_data),
        .rd_valid_o (b_rd_valid),
        .clear_i    (b_clear),
        .busy_o     (b_busy),
        .wr_drop_o  (b_wr_drop)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case a wait goes wrong
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drives instance A for one clock edge, then returns 1 ns after it
    task automatic applyStimulus(input logic we, input logic [5:0] waddr,
                                 input logic [7:0] wdata, input logic re,
                                 input logic [3:0] raddr, input logic clr);
        a_wr_en   = we;
        a_wr_addr = waddr;
        a_wr_data = wdata;
        a_rd_en   = re;
        a_rd_addr = raddr;
        a_clear   = clr;
        @(posedge clk);
        #1;
        a_wr_en   = 1'b0;
        a_rd_en   = 1'b0;
        a_clear   = 1'b0;
    endtask

    // Same for instance B
    task automatic applyStimulusB(input logic we, input logic [2:0] waddr,
                                  input logic [7:0] wdata, input logic re,
                                  input logic [1:0] raddr);
        b_wr_en   = we;
        b_wr_addr = waddr;
        b_wr_data = wdata;
        b_rd_en   = re;
        b_rd_addr = raddr;
        @(posedge clk);
        #1;
        b_wr_en   = 1'b0;
        b_rd_en   = 1'b0;
    endtask

    task automatic writeA(input logic [3:0] ch, input logic [1:0] lane,
                          input logic [7:0] data);
        applyStimulus(1'b1, {ch, lane}, data, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic readA(input logic [3:0] ch, input logic [31:0] exp,
                         input string tag);
        applyStimulus(1'b0, 6'd0, 8'd0, 1'b1, ch, 1'b0);
        checkOutput(tag, a_rd_data, exp);
        checkOutput({tag, "_valid"}, {31'd0, a_rd_valid}, 32'd1);
    endtask

    initial begin
        int busyCycles;
        int dropCount;
        int bHigh;

        errors    = 0;
        checks    = 0;
        rst       = 1'b1;
        a_wr_en   = 1'b0;
        a_wr_addr = '0;
        a_wr_data = '0;
        a_rd_en   = 1'b0;
        a_rd_addr = '0;
        a_clear   = 1'b0;
        b_wr_en   = 1'b0;
        b_wr_addr = '0;
        b_wr_data = '0;
        b_rd_en   = 1'b0;
        b_rd_addr = '0;
        b_clear   = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_rd_data", a_rd_data, 32'h0);
        checkOutput("rst_rd_valid", {31'd0, a_rd_valid}, 32'd0);
        checkOutput("rst_busy", {31'd0, a_busy}, 32'd1);
        checkOutput("rst_drop", {31'd0, a_wr_drop}, 32'd0);
        checkOutput("rst_b_busy", {31'd0, b_busy}, 32'd1);
        rst = 1'b0;

        // Test 1: writes during the post-reset clear are dropped
        $display("[TB] test 1: post-reset clear");
        busyCycles = 0;
        dropCount  = 0;
        bHigh      = 0;
        for (int i = 0; i < 16; i++) begin
            if (a_busy) busyCycles++;
            if (b_busy) bHigh++;
            writeA(4'd3, 2'd1, 8'hAB);
            if (a_wr_drop) dropCount++;
        end
        checkOutput("t1_busy_cycles", busyCycles, 16);
        checkOutput("t1_drop_count", dropCount, 16);
        checkOutput("t1_busy_low", {31'd0, a_busy}, 32'd0);
        checkOutput("t6_b_busy_cycles", bHigh, 4);
        checkOutput("t6_b_busy_low", {31'd0, b_busy}, 32'd0);
        writeA(4'd3, 2'd1, 8'hAB);
        checkOutput("t1_no_drop", {31'd0, a_wr_drop}, 32'd0);
        for (int ch = 0; ch < 16; ch++) begin
            readA(4'(ch), (ch == 3) ? 32'h0000AB00 : 32'h0, "t1_read");
        end
        applyStimulus(1'b0, 6'd0, 8'd0, 1'b0, 4'd0, 1'b0);
        checkOutput("t1_valid_drop", {31'd0, a_rd_valid}, 32'd0);

        // Test 2: byte-lane assembly
        $display("[TB] test 2: byte lanes");
        writeA(4'd15, 2'd0, 8'h11);
        writeA(4'd15, 2'd1, 8'h22);
        writeA(4'd15, 2'd2, 8'h33);
        writeA(4'd15, 2'd3, 8'h44);
        readA(4'd15, 32'h44332211, "t2_read");
        applyStimulus(1'b0, 6'd0, 8'd0, 1'b0, 4'd0, 1'b0);
        checkOutput("t2_valid_one_cycle", {31'd0, a_rd_valid}, 32'd0);
        checkOutput("t2_data_hold", a_rd_data, 32'h44332211);

        // Test 3: write-first collision and independent channels
        $display("[TB] test 3: collisions");
        writeA(4'd2, 2'd0, 8'hEF);
        writeA(4'd2, 2'd1, 8'hBE);
        writeA(4'd2, 2'd2, 8'hAD);
        writeA(4'd2, 2'd3, 8'hDE);
        readA(4'd2, 32'hDEADBEEF, "t3_pre");
        applyStimulus(1'b1, {4'd2, 2'd2}, 8'h00, 1'b1, 4'd2, 1'b0);
        checkOutput("t3_wf_collide", a_rd_data, 32'hDE00BEEF);
        applyStimulus(1'b1, {4'd5, 2'd0}, 8'h77, 1'b1, 4'd2, 1'b0);
        checkOutput("t3_diff_ch", a_rd_data, 32'hDE00BEEF);
        readA(4'd5, 32'h00000077, "t3_other");

        // Test 3/6 on instance B: read-first collision, small geometry
        applyStimulusB(1'b1, {2'd1, 1'b0}, 8'hEF, 1'b0, 2'd0);
        applyStimulusB(1'b1, {2'd1, 1'b1}, 8'hBE, 1'b0, 2'd0);
        applyStimulusB(1'b1, {2'd1, 1'b1}, 8'h00, 1'b1, 2'd1);
        checkOutput("t3_rf_collide", {16'd0, b_rd_data}, 32'h0000BEEF);
        applyStimulusB(1'b0, 3'd0, 8'd0, 1'b1, 2'd1);
        checkOutput("t3_rf_after", {16'd0, b_rd_data}, 32'h000000EF);
        applyStimulusB(1'b1, {2'd3, 1'b1}, 8'h5A, 1'b0, 2'd0);
        applyStimulusB(1'b0, 3'd0, 8'd0, 1'b1, 2'd3);
        checkOutput("t6_b_read", {16'd0, b_rd_data}, 32'h00005A00);
        checkOutput("t6_b_valid", {31'd0, b_rd_valid}, 32'd1);
        checkOutput("t6_b_drop", {31'd0, b_wr_drop}, 32'd0);

        // Test 4: clear restarted five cycles in
        $display("[TB] test 4: clear restart");
        applyStimulus(1'b0, 6'd0, 8'd0, 1'b0, 4'd0, 1'b1);
        checkOutput("t4_busy_start", {31'd0, a_busy}, 32'd1);
        busyCycles = 0;
        for (int i = 0; i < 100; i++) begin
            if (!a_busy) break;
            busyCycles++;
            if (i == 4) begin
                applyStimulus(1'b0, 6'd0, 8'd0, 1'b0, 4'd0, 1'b1);
            end else begin
                readA(4'(15 - (i % 16)), 32'h0, "t4_busy_read");
            end
        end
        checkOutput("t4_busy_cycles", busyCycles, 21);
        for (int ch = 0; ch < 16; ch++) begin
            readA(4'(ch), 32'h0, "t4_after");
        end

        // Test 5: reset during a read stream
        $display("[TB] test 5: reset mid-stream");
        for (int ch = 0; ch < 16; ch++) begin
            for (int l = 0; l < 4; l++) begin
                writeA(4'(ch), 2'(l), 8'hFF);
            end
        end
        readA(4'd7, 32'hFFFFFFFF, "t5_full");
        rst = 1'b1;
        applyStimulus(1'b0, 6'd0, 8'd0, 1'b1, 4'd7, 1'b0);
        checkOutput("t5_rst_valid", {31'd0, a_rd_valid}, 32'd0);
        checkOutput("t5_rst_data", a_rd_data, 32'h0);
        checkOutput("t5_rst_busy", {31'd0, a_busy}, 32'd1);
        rst = 1'b0;
        busyCycles = 0;
        for (int i = 0; i < 100; i++) begin
            if (!a_busy) break;
            busyCycles++;
            readA(4'(i % 16), 32'h0, "t5_busy_read");
        end
        checkOutput("t5_busy_cycles", busyCycles, 16);
        for (int ch = 0; ch < 16; ch++) begin
            readA(4'(ch), 32'h0, "t5_after");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
